// File: rtl/clause_bank_if.sv
// clause_bank_if: clause write, propagation control and result bundle for clause_bank
interface clause_bank_if #(
   parameter int NUM_VARS  = 8,
   parameter int WIDTH_LVL = 16,
   parameter int WIDTH_CID = 4
);
   logic                          wr_i;
   logic [WIDTH_CID-1:0]          wr_addr_i;
   logic [NUM_VARS*2-1:0]         clause_i;
   logic                          clear_i;
   logic                          start_i;
   logic [NUM_VARS*3-1:0]         var_value_i;
   logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_i;
   logic                          busy_o;
   logic                          done_o;
   logic [NUM_VARS*3-1:0]         var_value_o;
   logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_o;
   logic                          conflict_o;
   logic [WIDTH_CID-1:0]          conflict_cid_o;
   logic [WIDTH_LVL-1:0]          conflict_lvl_o;
   logic                          all_sat_o;
   logic [WIDTH_CID:0]            imp_cnt_o;
   modport master (
      output wr_i, wr_addr_i, clause_i, clear_i, start_i, var_value_i, var_lvl_i,
      input  busy_o, done_o, var_value_o, var_lvl_o, conflict_o, conflict_cid_o,
             conflict_lvl_o, all_sat_o, imp_cnt_o
   );
   modport slave (
      input  wr_i, wr_addr_i, clause_i, clear_i, start_i, var_value_i, var_lvl_i,
      output busy_o, done_o, var_value_o, var_lvl_o, conflict_o, conflict_cid_o,
             conflict_lvl_o, all_sat_o, imp_cnt_o
   );
endinterface

// File: rtl/clause_bank.sv
// clause_bank: clause store with sequential unit propagation and conflict detection
module clause_bank #(
   parameter int NUM_VARS    = 8,
   parameter int NUM_CLAUSES = 16,
   parameter int WIDTH_LVL   = 16,
   parameter int WIDTH_CID   = 4
) (
   input logic        clk,
   input logic        rst,
   clause_bank_if.slave bus
);
   localparam int VW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
   localparam logic [WIDTH_CID-1:0] LAST = WIDTH_CID'(NUM_CLAUSES - 1);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t                        state_q, state_d;
   logic [NUM_VARS*2-1:0]         mem_q [NUM_CLAUSES];
   logic [NUM_CLAUSES-1:0]        valid_q;
   logic [WIDTH_CID-1:0]          idx_q, idx_d, cid_q, cid_d;
   logic                          pass_q, pass_d, unsat_q, unsat_d;
   logic                          conflict_q, conflict_d, all_sat_q, all_sat_d, done_q;
   logic [NUM_VARS*3-1:0]         val_q, val_d;
   logic [NUM_VARS*WIDTH_LVL-1:0] lvl_q, lvl_d;
   logic [WIDTH_LVL-1:0]          clvl_q, clvl_d, false_lvl, lv;
   logic [WIDTH_CID:0]            imp_q, imp_d;
   logic [NUM_VARS*2-1:0]         cur;
   logic [1:0]                    lit, val;
   logic [VW-1:0]                 free_var;
   logic                          has_sat, free_seen, free_many, any_lit, unit, confl, unsat;
   // Classify the current slot against the work copy; invalid slots read as empty
   always_comb begin
      cur = valid_q[idx_q] ? mem_q[idx_q] : '0;
      has_sat = 1'b0;
      free_seen = 1'b0;
      free_many = 1'b0;
      any_lit = 1'b0;
      free_var = '0;
      false_lvl = '0;
      lit = '0;
      val = '0;
      lv = '0;
      for (int v = 0; v < NUM_VARS; v++) begin
         lit = cur[2*v +: 2];
         val = val_q[3*v +: 2];
         lv = lvl_q[v*WIDTH_LVL +: WIDTH_LVL];
         if (lit != 2'b00) begin
            any_lit = 1'b1;
            if (val == 2'b00) begin
               free_many = free_many | free_seen;
               free_seen = 1'b1;
               free_var = VW'(v);
            end else if (val == lit) has_sat = 1'b1;
            else if (lv > false_lvl) false_lvl = lv;
         end
      end
      unsat = any_lit & ~has_sat;
      unit = unsat & free_seen & ~free_many;
      confl = unsat & ~free_seen;
   end
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      pass_d = pass_q;
      unsat_d = unsat_q;
      val_d = val_q;
      lvl_d = lvl_q;
      imp_d = imp_q;
      conflict_d = conflict_q;
      cid_d = cid_q;
      clvl_d = clvl_q;
      all_sat_d = all_sat_q;
      if (state_q == IDLE && bus.start_i) begin
         state_d = SCAN;
         idx_d = '0;
         pass_d = 1'b0;
         unsat_d = 1'b0;
         val_d = bus.var_value_i;
         lvl_d = bus.var_lvl_i;
         imp_d = '0;
         conflict_d = 1'b0;
         cid_d = '0;
         clvl_d = '0;
         all_sat_d = 1'b0;
      end
      if (state_q == SCAN) begin
         if (unit) begin
            val_d[3*free_var +: 3] = {1'b1, cur[2*free_var +: 2]};
            lvl_d[free_var*WIDTH_LVL +: WIDTH_LVL] = false_lvl;
            imp_d = (&imp_q) ? imp_q : imp_q + 1'b1;
            pass_d = 1'b1;
         end
         if (confl) begin
            conflict_d = 1'b1;
            cid_d = idx_q;
            clvl_d = false_lvl;
            state_d = DONE;
         end else if (idx_q == LAST) begin
            if (pass_q | unit) begin
               pass_d = 1'b0;
               unsat_d = 1'b0;
               idx_d = '0;
            end else begin
               state_d = DONE;
               all_sat_d = ~(unsat_q | unsat);
            end
         end else begin
            idx_d = idx_q + 1'b1;
            unsat_d = unsat_q | unsat;
         end
      end
      if (state_q == DONE) state_d = IDLE;
   end
   always_ff @(posedge clk)
      if (state_q == IDLE && bus.wr_i && !bus.clear_i) mem_q[bus.wr_addr_i] <= bus.clause_i;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         idx_q <= '0;
         pass_q <= 1'b0;
         unsat_q <= 1'b0;
         val_q <= '0;
         lvl_q <= '0;
         imp_q <= '0;
         conflict_q <= 1'b0;
         cid_q <= '0;
         clvl_q <= '0;
         all_sat_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         pass_q <= pass_d;
         unsat_q <= unsat_d;
         val_q <= val_d;
         lvl_q <= lvl_d;
         imp_q <= imp_d;
         conflict_q <= conflict_d;
         cid_q <= cid_d;
         clvl_q <= clvl_d;
         all_sat_q <= all_sat_d;
         done_q <= state_q == DONE;
         if (state_q == IDLE && bus.clear_i) valid_q <= '0;
         else if (state_q == IDLE && bus.wr_i) valid_q[bus.wr_addr_i] <= |bus.clause_i;
      end
   end
   assign bus.busy_o = state_q != IDLE;
   assign bus.done_o = done_q;
   assign bus.var_value_o = val_q;
   assign bus.var_lvl_o = lvl_q;
   assign bus.conflict_o = conflict_q;
   assign bus.conflict_cid_o = cid_q;
   assign bus.conflict_lvl_o = clvl_q;
   assign bus.all_sat_o = all_sat_q;
   assign bus.imp_cnt_o = imp_q;
endmodule

// File: tb/tb_clause_bank.sv
// tb_clause_bank: directed and randomized checks of clause_bank against a propagation model
module tb_clause_bank;
   localparam int NV = 8, NC = 4, WL = 16, WC = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   clause_bank_if #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_CID(WC)) bus ();
   clause_bank #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_LVL(WL), .WIDTH_CID(WC))
      dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0, errors = 0;
   logic [2*NV-1:0] m_word [NC];
   bit m_valid [NC];
   int in_val [NV], in_imp [NV], in_lvl [NV];
   int e_val [NV], e_imp [NV], e_lvl [NV];
   int e_conf, e_cid, e_clvl, e_all, e_imp_cnt, e_lat;
   logic [3*NV-1:0] e_vv;
   logic [WL*NV-1:0] e_vl;

   task automatic apply_vars();
      for (int v = 0; v < NV; v++) begin
         bus.var_value_i[3*v +: 3] = {in_imp[v][0], in_val[v][1:0]};
         bus.var_lvl_i[v*WL +: WL] = in_lvl[v][WL-1:0];
      end
   endtask

   task automatic do_write(input int s, input logic [2*NV-1:0] w);
      @(negedge clk);
      bus.wr_i = 1'b1;
      bus.wr_addr_i = WC'(s);
      bus.clause_i = w;
      @(negedge clk);
      bus.wr_i = 1'b0;
      m_word[s] = w;
      m_valid[s] = (w != '0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus.clear_i = 1'b1;
      @(negedge clk);
      bus.clear_i = 1'b0;
      for (int s = 0; s < NC; s++) m_valid[s] = 1'b0;
   endtask

   task automatic run(output int lat);
      apply_vars();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      lat = 0;
      while (bus.done_o !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Slot-by-slot propagation over whole passes, with the cycle cost of each slot visit
   task automatic model_run();
      bit fin = 0;
      for (int v = 0; v < NV; v++) begin
         e_val[v] = in_val[v];
         e_imp[v] = in_imp[v];
         e_lvl[v] = in_lvl[v];
      end
      e_imp_cnt = 0; e_conf = 0; e_cid = 0; e_clvl = 0; e_all = 0; e_lat = 0;
      for (int p = 0; p <= NV + 1 && !fin; p++) begin
         bit changed = 0, all_ok = 1;
         for (int s = 0; s < NC && !fin; s++) begin
            int nsat = 0, nfree = 0, fv = 0, mx = 0;
            if (!m_valid[s]) continue;
            for (int v = 0; v < NV; v++) begin
               int l = int'(m_word[s][2*v +: 2]);
               if (l == 0) continue;
               if (e_val[v] == 0) begin nfree++; fv = v; end
               else if (e_val[v] == l) nsat++;
               else if (e_lvl[v] > mx) mx = e_lvl[v];
            end
            if (nsat > 0) continue;
            all_ok = 0;
            if (nfree == 1) begin
               e_val[fv] = int'(m_word[s][2*fv +: 2]);
               e_imp[fv] = 1;
               e_lvl[fv] = mx;
               e_imp_cnt = (e_imp_cnt + 1 > 2**(WC+1) - 1) ? 2**(WC+1) - 1 : e_imp_cnt + 1;
               changed = 1;
            end else if (nfree == 0) begin
               e_conf = 1; e_cid = s; e_clvl = mx; e_lat = p*NC + s + 2; fin = 1;
            end
         end
         if (!fin && !changed) begin
            fin = 1; e_all = all_ok; e_lat = (p + 1)*NC + 1;
         end
      end
      for (int v = 0; v < NV; v++) begin
         e_vv[3*v +: 3] = {e_imp[v][0], e_val[v][1:0]};
         e_vl[v*WL +: WL] = e_lvl[v][WL-1:0];
      end
   endtask

   task automatic test_reset();
      bus.wr_i = 0; bus.wr_addr_i = '0; bus.clause_i = '0; bus.clear_i = 0; bus.start_i = 0;
      bus.var_value_i = '0; bus.var_lvl_i = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.done_o, bus.conflict_o, bus.all_sat_o} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy_o, bus.done_o, bus.conflict_o, bus.all_sat_o});
      end
      checks++;
      if ({bus.imp_cnt_o, bus.conflict_cid_o, bus.conflict_lvl_o} !== '0) begin
         errors++; $display("FAIL reset_counts: imp %0h cid %0h lvl %0h expected 0", bus.imp_cnt_o, bus.conflict_cid_o, bus.conflict_lvl_o);
      end
      checks++;
      if ({bus.var_value_o, bus.var_lvl_o} !== '0) begin
         errors++; $display("FAIL reset_vars: got %0h / %0h expected 0", bus.var_value_o, bus.var_lvl_o);
      end
      rst = 1'b0;
      for (int s = 0; s < NC; s++) m_valid[s] = 1'b0;
   endtask

   task automatic test_directed();
      int c_lat [4] = '{5, 9, 9, 4};
      int c_imp [4] = '{0, 1, 2, 1};
      int c_conf [4] = '{0, 0, 0, 1};
      int c_all [4] = '{1, 1, 1, 0};
      for (int d = 0; d < 4; d++) begin
         int lat;
         logic [2*NV-1:0] w0, w1;
         do_clear();
         for (int v = 0; v < NV; v++) begin in_val[v] = 0; in_imp[v] = 0; in_lvl[v] = v + 1; end
         w0 = '0; w1 = '0;
         if (d == 0) begin
            w0[3:2] = 2'b01; w0[7:6] = 2'b10; w0[11:10] = 2'b10;
            in_val[1] = 1; in_val[5] = 1;
            do_write(0, w0);
         end else if (d == 1) begin
            w0[3:2] = 2'b10; w0[11:10] = 2'b01;
            in_val[1] = 1;
            do_write(0, w0);
         end else if (d == 2) begin
            w0[1:0] = 2'b10; w0[7:6] = 2'b01;
            w1[7:6] = 2'b10; w1[11:10] = 2'b01;
            in_val[0] = 1;
            do_write(0, w0);
            do_write(1, w1);
         end else begin
            w0[1:0] = 2'b01; w0[15:14] = 2'b10;
            w1[5:4] = 2'b01; w1[11:10] = 2'b01;
            in_val[7] = 1; in_val[2] = 2; in_val[5] = 2;
            do_write(0, w0);
            do_write(2, w1);
         end
         model_run();
         run(lat);
         checks++;
         if (lat !== c_lat[d] || lat !== e_lat) begin
            errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", d, lat, c_lat[d]);
         end
         checks++;
         if (bus.imp_cnt_o !== c_imp[d] || bus.conflict_o !== c_conf[d][0] || bus.all_sat_o !== c_all[d][0]) begin
            errors++; $display("FAIL dir%0d_result: imp %0d conf %b all_sat %b expected %0d %0d %0d",
                               d, bus.imp_cnt_o, bus.conflict_o, bus.all_sat_o, c_imp[d], c_conf[d], c_all[d]);
         end
         checks++;
         if (bus.var_value_o !== e_vv || bus.var_lvl_o !== e_vl) begin
            errors++; $display("FAIL dir%0d_vars: got %0h / %0h expected %0h / %0h", d, bus.var_value_o, bus.var_lvl_o, e_vv, e_vl);
         end
         checks++;
         if (bus.conflict_cid_o !== e_cid || bus.conflict_lvl_o !== e_clvl) begin
            errors++; $display("FAIL dir%0d_conflict_info: cid %0d lvl %0d expected %0d %0d", d, bus.conflict_cid_o, bus.conflict_lvl_o, e_cid, e_clvl);
         end
         if (d == 1) begin
            checks++;
            if (bus.var_value_o[17:15] !== 3'b101 || bus.var_lvl_o[5*WL +: WL] !== 16'd2) begin
               errors++; $display("FAIL dir1_var5: got %b lvl %0d expected 101 lvl 2", bus.var_value_o[17:15], bus.var_lvl_o[5*WL +: WL]);
            end
         end
         if (d == 3) begin
            checks++;
            if (bus.conflict_cid_o !== 2'd2 || bus.conflict_lvl_o !== 16'd6 || bus.var_value_o[2:0] !== 3'b101) begin
               errors++; $display("FAIL dir3_conflict: cid %0d lvl %0d var0 %b expected 2 6 101", bus.conflict_cid_o, bus.conflict_lvl_o, bus.var_value_o[2:0]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int lat;
         if (it % 7 == 0) do_clear();
         for (int s = 0; s < NC; s++) begin
            logic [2*NV-1:0] w = '0;
            if ($urandom_range(0, 2) == 0) continue;
            if ($urandom_range(0, 5) != 0)
               for (int v = 0; v < NV; v++) begin
                  int r = $urandom_range(0, 9);
                  w[2*v +: 2] = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : 2'b10;
               end
            do_write(s, w);
         end
         for (int v = 0; v < NV; v++) begin
            int r = $urandom_range(0, 3);
            in_val[v] = (r < 2) ? 0 : r - 1;
            in_imp[v] = $urandom_range(0, 1);
            in_lvl[v] = $urandom_range(0, 65535);
         end
         model_run();
         run(lat);
         checks++;
         if (lat !== e_lat) begin
            errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, lat, e_lat);
         end
         checks++;
         if (bus.conflict_o !== e_conf[0] || bus.conflict_cid_o !== e_cid || bus.conflict_lvl_o !== e_clvl) begin
            errors++; $display("FAIL rnd%0d_conflict: got %b cid %0d lvl %0d expected %0d %0d %0d",
                               it, bus.conflict_o, bus.conflict_cid_o, bus.conflict_lvl_o, e_conf, e_cid, e_clvl);
         end
         checks++;
         if (bus.all_sat_o !== e_all[0] || bus.imp_cnt_o !== e_imp_cnt) begin
            errors++; $display("FAIL rnd%0d_sat_imp: all_sat %b imp %0d expected %0d %0d", it, bus.all_sat_o, bus.imp_cnt_o, e_all, e_imp_cnt);
         end
         checks++;
         if (bus.var_value_o !== e_vv || bus.var_lvl_o !== e_vl) begin
            errors++; $display("FAIL rnd%0d_vars: got %0h / %0h expected %0h / %0h", it, bus.var_value_o, bus.var_lvl_o, e_vv, e_vl);
         end
         @(negedge clk);
         checks++;
         if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.var_value_o !== e_vv) begin
            errors++; $display("FAIL rnd%0d_pulse_hold: done %b busy %b vars %0h expected 0 0 %0h", it, bus.done_o, bus.busy_o, bus.var_value_o, e_vv);
         end
      end
   endtask

   task automatic test_busy_write();
      int lat;
      logic [2*NV-1:0] w = '0;
      do_clear();
      w[1:0] = 2'b01;
      do_write(0, w);
      for (int v = 0; v < NV; v++) begin in_val[v] = 0; in_imp[v] = 0; in_lvl[v] = 10 + v; end
      apply_vars();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b1) begin
         errors++; $display("FAIL busy_asserted: got %b expected 1", bus.busy_o);
      end
      bus.wr_i = 1'b1; bus.wr_addr_i = '0; bus.clause_i = 16'h0002;
      @(negedge clk);
      bus.wr_i = 1'b0; bus.clear_i = 1'b1;
      @(negedge clk);
      bus.clear_i = 1'b0;
      lat = 0;
      while (bus.done_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      checks++;
      if (lat >= 200) begin
         errors++; $display("FAIL busy_wait: done not seen within %0d cycles", lat);
      end
      model_run();
      run(lat);
      checks++;
      if (lat !== 9 || bus.imp_cnt_o !== e_imp_cnt || bus.var_value_o !== e_vv) begin
         errors++; $display("FAIL busy_write_ignored: lat %0d imp %0d vars %0h expected 9 %0d %0h", lat, bus.imp_cnt_o, bus.var_value_o, e_imp_cnt, e_vv);
      end
   endtask

   task automatic test_reset_midscan();
      int lat;
      logic [2*NV-1:0] w = '0;
      w[3:2] = 2'b10;
      do_write(1, w);
      for (int v = 0; v < NV; v++) begin in_val[v] = 0; in_imp[v] = 1; in_lvl[v] = 7; end
      apply_vars();
      @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.var_value_o !== '0 || bus.var_lvl_o !== '0) begin
         errors++; $display("FAIL rst_async: busy %b vars %0h lvl %0h expected 0", bus.busy_o, bus.var_value_o, bus.var_lvl_o);
      end
      for (int s = 0; s < NC; s++) m_valid[s] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      lat = 0;
      while (bus.done_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      model_run();
      checks++;
      if (lat !== 5 || lat !== e_lat || bus.all_sat_o !== 1'b1 || bus.imp_cnt_o !== '0) begin
         errors++; $display("FAIL rst_restart: lat %0d all_sat %b imp %0d expected 5 1 0", lat, bus.all_sat_o, bus.imp_cnt_o);
      end
   endtask

   task automatic test_clear_wins();
      int lat;
      logic [2*NV-1:0] w = '0;
      w[1:0] = 2'b01;
      for (int v = 0; v < NV; v++) begin in_val[v] = 2; in_imp[v] = 0; in_lvl[v] = v; end
      do_write(1, w);
      @(negedge clk);
      bus.clear_i = 1'b1; bus.wr_i = 1'b1; bus.wr_addr_i = 2'd2; bus.clause_i = w;
      @(negedge clk);
      bus.clear_i = 1'b0; bus.wr_i = 1'b0;
      for (int s = 0; s < NC; s++) m_valid[s] = 1'b0;
      run(lat);
      checks++;
      if (lat !== 5 || bus.conflict_o !== 1'b0 || bus.all_sat_o !== 1'b1) begin
         errors++; $display("FAIL clear_wins: lat %0d conflict %b all_sat %b expected 5 0 1", lat, bus.conflict_o, bus.all_sat_o);
      end
      do_write(3, w);
      do_write(3, '0);
      model_run();
      run(lat);
      checks++;
      if (bus.conflict_o !== 1'b0 || bus.all_sat_o !== 1'b1 || lat !== e_lat) begin
         errors++; $display("FAIL zero_write_invalidates: conflict %b all_sat %b lat %0d expected 0 1 %0d", bus.conflict_o, bus.all_sat_o, lat, e_lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_write();
      test_reset_midscan();
      test_clear_wins();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
